// File: rtl/msk_unmask_seq.sv
// msk_unmask_seq -- sequential unmasking of a d-share Boolean sharing.
//
// Accepts a count-bit value split into d Boolean shares and recombines it
// one share per clock into an accumulator. No logic cone ever XORs all of
// a bit's shares at once; the only place shares meet is the acc register.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_shares  sharing; share j of bit i sits at bit i*d+j
//   in_valid   in_shares valid
//   in_ready   block can accept a sharing (registered, high only in IDLE)
//   out_data   recombined plaintext, forced to 0 while out_valid is low
//   out_valid  out_data valid (registered, high only in DONE)
//   out_ready  consumer accepts out_data
//
// state  | meaning
// S_IDLE | waiting for a sharing, in_ready=1
// S_ACCUM| folding share cnt into acc, one share per cycle
// S_DONE | plaintext presented, waiting for out_ready

module msk_unmask_seq #(
  parameter int d     = 2,
  parameter int count = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [count*d-1:0]   in_shares,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [count-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int              CW       = (d > 1) ? $clog2(d) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(d - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q;
  logic [count*d-1:0]   share_q;
  logic [count-1:0]     acc_q;
  logic [count-1:0]     acc_d;
  logic [count-1:0]     first_share;
  logic [CW-1:0]        cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic [d-1:0]         bit_shares;

  // Registered-index mux: pick share cnt_q of every bit out of share_q and
  // fold it into the running sum. first_share only taps share 0 of the
  // incoming sharing, so no two shares are combined here either.
  always_comb begin
    acc_d       = acc_q;
    first_share = '0;
    bit_shares  = '0;
    for (int i = 0; i < count; i++) begin
      bit_shares     = share_q[i*d +: d];
      acc_d[i]       = acc_q[i] ^ bit_shares[cnt_q];
      first_share[i] = in_shares[i*d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      share_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            share_q    <= in_shares;
            acc_q      <= first_share;
            cnt_q      <= CNT_ONE;
            in_ready_q <= 1'b0;
            if (d == 1) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_ACCUM: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          // Zeroise the sharing and the sum as soon as the consumer takes it.
          if (out_ready) begin
            state_q     <= S_IDLE;
            share_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          share_q     <= '0;
          acc_q       <= '0;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  // Partial sums never leave the block.
  assign out_data  = acc_q & {count{out_valid_q}};

endmodule

// File: tb/tb_msk_unmask_seq.sv
module tb_msk_unmask_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // d=3, count=4
  logic        rst3, iv3, ir3, ov3, or3;
  logic [11:0] ish3;
  logic [3:0]  od3;
  // d=1, count=8
  logic        rst1, iv1, ir1, ov1, or1;
  logic [7:0]  ish1, od1;
  // d=2, count=2
  logic        rst2, iv2, ir2, ov2, or2;
  logic [3:0]  ish2;
  logic [1:0]  od2;
  // d=4, count=8
  logic        rst4, iv4, ir4, ov4, or4;
  logic [31:0] ish4;
  logic [7:0]  od4;

  msk_unmask_seq #(.d(3), .count(4)) dut3 (
    .clk(clk), .rst(rst3), .in_shares(ish3), .in_valid(iv3), .in_ready(ir3),
    .out_data(od3), .out_valid(ov3), .out_ready(or3));
  msk_unmask_seq #(.d(1), .count(8)) dut1 (
    .clk(clk), .rst(rst1), .in_shares(ish1), .in_valid(iv1), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(or1));
  msk_unmask_seq #(.d(2), .count(2)) dut2 (
    .clk(clk), .rst(rst2), .in_shares(ish2), .in_valid(iv2), .in_ready(ir2),
    .out_data(od2), .out_valid(ov2), .out_ready(or2));
  msk_unmask_seq #(.d(4), .count(8)) dut4 (
    .clk(clk), .rst(rst4), .in_shares(ish4), .in_valid(iv4), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(or4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to mid-cycle, where outputs are sampled.
  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [7:0] unmask4(input logic [31:0] sh);
    logic [7:0] r;
    logic [3:0] s;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      s    = sh[i*4 +: 4];
      r[i] = s[0] ^ s[1] ^ s[2] ^ s[3];
    end
    return r;
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  int         n_out;
  int         n_in;
  int         guard;

  initial begin
    rst3 = 1'b1; rst1 = 1'b1; rst2 = 1'b1; rst4 = 1'b1;
    iv3 = 1'b0; iv1 = 1'b0; iv2 = 1'b0; iv4 = 1'b0;
    or3 = 1'b0; or1 = 1'b0; or2 = 1'b0; or4 = 1'b0;
    ish3 = '0; ish1 = '0; ish2 = '0; ish4 = '0;
    tick();
    tick();
    rst3 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst4 = 1'b0;
    sample();
    chk("rst_in_ready",  32'(ir3), 32'd1);
    chk("rst_out_valid", 32'(ov3), 32'd0);
    chk("rst_out_data",  32'(od3), 32'd0);
    chk("rst_acc",       32'(dut3.acc_q), 32'd0);

    // 1: d=3 basic, out_ready high
    tick();
    iv3 = 1'b1; ish3 = 12'hE0B; or3 = 1'b1;
    sample();
    chk("t1_c0_ready", 32'(ir3), 32'd1);
    tick();
    iv3 = 1'b0;
    sample();
    chk("t1_c1_ready", 32'(ir3), 32'd0);
    chk("t1_c1_valid", 32'(ov3), 32'd0);
    tick(); sample();
    chk("t1_c2_valid", 32'(ov3), 32'd0);
    chk("t1_c2_data",  32'(od3), 32'd0);
    tick(); sample();
    chk("t1_c3_valid", 32'(ov3), 32'd1);
    chk("t1_c3_data",  32'(od3), 32'hA);
    chk("t1_c3_ready", 32'(ir3), 32'd0);
    tick(); sample();
    chk("t1_c4_ready", 32'(ir3), 32'd1);
    chk("t1_c4_valid", 32'(ov3), 32'd0);
    chk("t1_c4_acc",   32'(dut3.acc_q), 32'd0);
    chk("t1_c4_share", 32'(dut3.share_q), 32'd0);

    // 2: d=3, consumer stalls until cycle 7
    tick();
    iv3 = 1'b1; ish3 = 12'hE0B; or3 = 1'b0;
    sample();
    for (int c = 1; c <= 7; c++) begin
      tick();
      iv3 = 1'b0;
      if (c == 7) or3 = 1'b1;
      sample();
      chk($sformatf("t2_c%0d_valid", c), 32'(ov3), (c >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("t2_c%0d_data", c),  32'(od3), (c >= 3) ? 32'hA : 32'd0);
      chk($sformatf("t2_c%0d_ready", c), 32'(ir3), 32'd0);
    end
    tick(); sample();
    chk("t2_c8_ready", 32'(ir3), 32'd1);
    chk("t2_c8_valid", 32'(ov3), 32'd0);
    chk("t2_c8_state", 32'(dut3.state_q), 32'd0);

    // 5: d=3, in_valid held across two sharings
    tick();
    iv3 = 1'b1; ish3 = 12'hE0B; or3 = 1'b1;
    sample();
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) begin
        tick();
        ish3 = 12'h000;
        if (c == 5) iv3 = 1'b0;
        sample();
      end
      chk($sformatf("t5_c%0d_valid", c), 32'(ov3), (c == 3 || c == 7) ? 32'd1 : 32'd0);
      chk($sformatf("t5_c%0d_data", c),  32'(od3), (c == 3) ? 32'hA : 32'd0);
      chk($sformatf("t5_c%0d_ready", c), 32'(ir3), (c == 0 || c == 4 || c == 8) ? 32'd1 : 32'd0);
    end

    // 3: d=1 passes the single share straight through
    tick();
    iv1 = 1'b1; ish1 = 8'h5C; or1 = 1'b1;
    sample();
    chk("t3_c0_valid", 32'(ov1), 32'd0);
    tick();
    iv1 = 1'b0;
    sample();
    chk("t3_c1_valid", 32'(ov1), 32'd1);
    chk("t3_c1_data",  32'(od1), 32'h5C);
    chk("t3_c1_ready", 32'(ir1), 32'd0);
    tick(); sample();
    chk("t3_c2_ready", 32'(ir1), 32'd1);
    chk("t3_c2_valid", 32'(ov1), 32'd0);

    // 4: d=2, normal pass then reset mid-operation
    tick();
    iv2 = 1'b1; ish2 = 4'b1101; or2 = 1'b1;
    sample();
    tick();
    iv2 = 1'b0;
    sample();
    chk("t4_c1_valid", 32'(ov2), 32'd0);
    tick(); sample();
    chk("t4_c2_valid", 32'(ov2), 32'd1);
    chk("t4_c2_data",  32'(od2), 32'b01);
    tick(); sample();
    chk("t4_c3_ready", 32'(ir2), 32'd1);
    tick();
    iv2 = 1'b1; ish2 = 4'b1101;
    sample();
    tick();
    iv2 = 1'b0; rst2 = 1'b1;
    sample();
    chk("t4r_c1_valid", 32'(ov2), 32'd0);
    tick();
    rst2 = 1'b0;
    sample();
    chk("t4r_c2_valid", 32'(ov2), 32'd0);
    chk("t4r_c2_ready", 32'(ir2), 32'd1);
    chk("t4r_c2_share", 32'(dut2.share_q), 32'd0);
    chk("t4r_c2_data",  32'(od2), 32'd0);
    for (int c = 3; c <= 5; c++) begin
      tick(); sample();
      chk($sformatf("t4r_c%0d_valid", c), 32'(ov2), 32'd0);
    end

    // 6: d=4, count=8, random shares and random consumer stalls
    n_out = 0;
    n_in  = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      iv4  = ($urandom_range(0, 3) != 0);
      ish4 = $urandom;
      or4  = ($urandom_range(0, 2) != 0);
      sample();
      if (!ov4) chk("t6_idle_data", 32'(od4), 32'd0);
      if (ov4 && or4) begin
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("t6_data", 32'(od4), 32'(exp_v));
        n_out++;
      end
      if (iv4 && ir4) begin
        exp_q.push_back(unmask4(ish4));
        n_in++;
      end
    end
    tick();
    iv4 = 1'b0; or4 = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      sample();
      if (ov4) begin
        exp_v = exp_q.pop_front();
        chk("t6_drain_data", 32'(od4), 32'(exp_v));
        n_out++;
      end
      tick();
      guard++;
    end
    sample();
    chk("t6_pending", 32'(exp_q.size()), 32'd0);
    chk("t6_count",   32'(n_out), 32'(n_in));
    chk("t6_final_valid", 32'(ov4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
